// File: rtl/bkt_lvl_finder_if.sv
// Requester-side handshake of the backtrack-level finder.
// The requester (conflict analysis) drives start/bound/ack.
// The finder returns busy, done and the backtrack result.
interface bkt_lvl_finder_if #(
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_BIN_ID = 10
);
    logic                    start_i;
    logic [WIDTH_LVL-1:0]    max_lvl_i;
    logic                    ack_i;
    logic                    busy_o;
    logic                    done_o;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_o;
    logic [WIDTH_LVL-1:0]    bkt_lvl_o;
    logic                    unsat_o;
    logic                    multi_hit_o;

    modport master (
        output start_i, max_lvl_i, ack_i,
        input  busy_o, done_o, bkt_bin_o, bkt_lvl_o, unsat_o, multi_hit_o
    );

    modport slave (
        input  start_i, max_lvl_i, ack_i,
        output busy_o, done_o, bkt_bin_o, bkt_lvl_o, unsat_o, multi_hit_o
    );
endinterface

// File: rtl/bkt_lvl_finder.sv
// Backtrack-level controller for the level-state chain.
// It registers the search bound into the chain and waits one cycle for the
// cells' registered reports. It then OR-reduces the reports into one result,
// strobes apply_bkt when a level was found, and holds the result until ack.
module bkt_lvl_finder #(
    parameter int NUM_LVL      = 32,
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_BIN_ID = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    bkt_lvl_finder_if.slave                 req,
    output logic [WIDTH_LVL-1:0]            max_lvl_o,
    output logic [1:0]                      findflag_head_o,
    output logic [WIDTH_LVL-1:0]            lvl_base_o,
    input  logic [NUM_LVL*WIDTH_BIN_ID-1:0] bkt_bin_all_i,
    input  logic [NUM_LVL*WIDTH_LVL-1:0]    bkt_lvl_all_i,
    output logic                            apply_bkt_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOUND  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_APPLY  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  state_r;
    logic [WIDTH_LVL-1:0]    max_lvl_r;
    logic                    apply_r;
    logic                    busy_r;
    logic                    done_r;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_r;
    logic [WIDTH_LVL-1:0]    bkt_lvl_r;
    logic                    unsat_r;
    logic                    multi_hit_r;

    logic [WIDTH_BIN_ID-1:0] or_bin_s;
    logic [WIDTH_LVL-1:0]    or_lvl_s;
    logic                    hit_one_s;
    logic                    hit_many_s;
    logic                    slice_nz_s;

    // Chain head constants: no find flag enters from the left, levels start at 1
    // so that a zero level slice unambiguously means "no hit".
    assign findflag_head_o = 2'b00;
    assign lvl_base_o      = {{(WIDTH_LVL-1){1'b0}}, 1'b1};

    assign max_lvl_o       = max_lvl_r;
    assign apply_bkt_o     = apply_r;
    assign req.busy_o      = busy_r;
    assign req.done_o      = done_r;
    assign req.bkt_bin_o   = bkt_bin_r;
    assign req.bkt_lvl_o   = bkt_lvl_r;
    assign req.unsat_o     = unsat_r;
    assign req.multi_hit_o = multi_hit_r;

    // OR-reduce the per-cell reports and detect more than one nonzero level slice.
    always_comb begin
        or_bin_s   = '0;
        or_lvl_s   = '0;
        hit_one_s  = 1'b0;
        hit_many_s = 1'b0;
        slice_nz_s = 1'b0;
        for (int i = 0; i < NUM_LVL; i++) begin
            slice_nz_s = |bkt_lvl_all_i[i*WIDTH_LVL +: WIDTH_LVL];
            or_bin_s   = or_bin_s | bkt_bin_all_i[i*WIDTH_BIN_ID +: WIDTH_BIN_ID];
            or_lvl_s   = or_lvl_s | bkt_lvl_all_i[i*WIDTH_LVL +: WIDTH_LVL];
            hit_many_s = hit_many_s | (hit_one_s & slice_nz_s);
            hit_one_s  = hit_one_s | slice_nz_s;
        end
    end

    // Sequencer: bound -> wait for cell registers -> sample -> optional apply -> hold result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            max_lvl_r   <= '0;
            apply_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bkt_bin_r   <= '0;
            bkt_lvl_r   <= '0;
            unsat_r     <= 1'b0;
            multi_hit_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    apply_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (req.start_i) begin
                        // The bound stays on the chain afterwards so cells never see a glitch.
                        max_lvl_r <= req.max_lvl_i;
                        busy_r    <= 1'b1;
                        state_r   <= ST_BOUND;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_BOUND: begin
                    // Cells register their reports at the end of this cycle.
                    state_r <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    bkt_bin_r   <= or_bin_s;
                    bkt_lvl_r   <= or_lvl_s;
                    multi_hit_r <= hit_many_s;
                    unsat_r     <= (or_lvl_s == '0);
                    if (or_lvl_s == '0) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        apply_r <= 1'b1;
                        state_r <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    apply_r <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if (req.ack_i) begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    apply_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
